// File: rtl/mem_sequencer.sv
// mem_sequencer: multicycle control sequencer placing an RV32I datapath on one shared instruction/data memory port.
// Latency: 2 cycles per non-memory instruction and 4 per load/store at zero wait; each memory wait cycle adds 1.
// Backpressure: a request is held until mem_ack; after TIMEOUT unacked request cycles the core parks in HALT.
//
// Ports:
//   clk, rst                        core clock, asynchronous active-high reset
//   pc, alu_result, write_data,     datapath inputs; held stable until commit
//   byte_en, is_load, is_store
//   instr, read_data                latched fetch word and load data
//   commit                          one-cycle PC / RegWrite enable
//   mem_req/we/addr/wdata/be        combinational memory request
//   mem_rdata, mem_ack              memory response
//   halted, instret                 fault flag and retired-instruction count
module mem_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  input  logic        is_load,
  input  logic        is_store,
  output logic [31:0] instr,
  output logic [31:0] read_data,
  output logic        commit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        halted,
  output logic [31:0] instret
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            is_mem;
  logic            in_xfer;

  assign is_mem  = is_load | is_store;
  assign in_xfer = (state == S_FETCH) || (state == S_MEM);

  // The counter holds the number of unacked cycles already spent on the
  // current request, so this cycle is the TIMEOUT-th one when it reads
  // TIMEOUT-1. An ack in that same cycle is checked first and wins.
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));

  // HALT is only reachable through the watchdog and has no exit, so the
  // state itself is the sticky fault flag.
  assign halted = (state == S_HALT);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        mem_be   = 4'hF;
        if (mem_ack) begin
          state_nxt = S_EXEC;
        end else if (wd_expire) begin
          state_nxt = S_HALT;
        end
      end
      S_EXEC: begin
        if (is_mem) begin
          state_nxt = S_MEM;
        end else begin
          commit    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        // is_store dominates, so both decoder flags high behaves as a store.
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = alu_result;
        mem_wdata = write_data;
        mem_be    = is_store ? byte_en : 4'hF;
        if (mem_ack) begin
          state_nxt = S_WB;
        end else if (wd_expire) begin
          state_nxt = S_HALT;
        end
      end
      S_WB: begin
        commit    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wd_cnt    <= '0;
      instr     <= '0;
      read_data <= '0;
      instret   <= '0;
    end else begin
      state <= state_nxt;

      // Count only while a request stays outstanding; any state change
      // (ack, timeout or entry into a new request) restarts from zero.
      if (in_xfer && (state_nxt == state)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end

      if ((state == S_FETCH) && mem_ack) begin
        instr <= mem_rdata;
      end

      if ((state == S_MEM) && mem_ack && !is_store) begin
        read_data <= mem_rdata;
      end

      if (commit) begin
        instret <= instret + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed bench for mem_sequencer with a per-cycle expected-behaviour model.
// Latency: the model expands each instruction into its expected cycles from the timing rules.
// Backpressure: the memory responder inserts the wait states listed per instruction.
module tb_mem_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  byte_en = '0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [31:0] instr;
  logic [31:0] read_data;
  logic        commit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        halted;
  logic [31:0] instret;

  mem_sequencer #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .alu_result(alu_result),
    .write_data(write_data),
    .byte_en   (byte_en),
    .is_load   (is_load),
    .is_store  (is_store),
    .instr     (instr),
    .read_data (read_data),
    .commit    (commit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted),
    .instret   (instret)
  );

  initial forever #5 clk = ~clk;

  // kind: 0 = ALU, 1 = load, 2 = store, 3 = load+store flags (a store)
  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] iword;
    logic [31:0] rdata;
    int          fw;
    int          mw;
    bit          hang;
  } ins_t;

  typedef struct {
    int          idx;
    bit          req;
    bit          we;
    bit          fetch;
    bit          commit;
    bit          ack;
    bit          halted;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] instr;
    logic [31:0] rd;
    logic [31:0] instret;
  } cyc_t;

  ins_t prog[$];
  cyc_t exp_q[$];
  int   commits[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   phase = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic ins_t mk(int kind, logic [31:0] p, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] be, logic [31:0] iw, logic [31:0] rd,
                              int fw, int mw, bit hang);
    ins_t i;
    i.kind = kind; i.pc = p; i.addr = a; i.wdata = wd; i.be = be;
    i.iword = iw; i.rdata = rd; i.fw = fw; i.mw = mw; i.hang = hang;
    return i;
  endfunction

  function automatic cyc_t blank(int idx, logic [31:0] iv, logic [31:0] rv, logic [31:0] ir);
    cyc_t c;
    c.idx = idx; c.req = 0; c.we = 0; c.fetch = 0; c.commit = 0; c.ack = 0; c.halted = 0;
    c.addr = '0; c.wdata = '0; c.rdata = '0; c.be = '0;
    c.instr = iv; c.rd = rv; c.instret = ir;
    return c;
  endfunction

  // Expected cycle-by-cycle behaviour of a program starting right after reset.
  // Stray acks in non-request cycles carry junk data that must be ignored.
  task automatic expand(logic [31:0] ir0);
    logic [31:0] iv;
    logic [31:0] rv;
    logic [31:0] ir;
    ins_t        p;
    cyc_t        c;
    int          n;
    bit          st;
    iv = '0; rv = '0; ir = ir0;
    exp_q.delete();
    exp_q.push_back(blank(0, iv, rv, ir));
    for (int i = 0; i < prog.size(); i++) begin
      p = prog[i];
      n = p.hang ? TO : p.fw + 1;
      for (int k = 0; k < n; k++) begin
        c = blank(i, iv, rv, ir);
        c.req = 1; c.fetch = 1; c.addr = p.pc; c.be = 4'hF;
        c.ack = !p.hang && (k == n - 1);
        c.rdata = c.ack ? p.iword : (32'hBAD0_0000 | 32'(k));
        exp_q.push_back(c);
      end
      if (p.hang) begin
        for (int k = 0; k < 3; k++) begin
          c = blank(i, iv, rv, ir);
          c.halted = 1; c.ack = 1; c.rdata = 32'h0BAD_0000 | 32'(k);
          exp_q.push_back(c);
        end
        break;
      end
      iv = p.iword;
      c = blank(i, iv, rv, ir);
      c.ack = 1; c.rdata = 32'hFEED_0000 | 32'(i);
      if (p.kind == 0) begin
        c.commit = 1;
        exp_q.push_back(c);
        ir = ir + 1;
        continue;
      end
      exp_q.push_back(c);
      st = (p.kind >= 2);
      for (int k = 0; k <= p.mw; k++) begin
        c = blank(i, iv, rv, ir);
        c.req = 1; c.we = st; c.addr = p.addr; c.wdata = p.wdata;
        c.be = st ? p.be : 4'hF;
        c.ack = (k == p.mw);
        c.rdata = c.ack ? p.rdata : (32'hBAD1_0000 | 32'(k));
        exp_q.push_back(c);
      end
      if (!st) rv = p.rdata;
      c = blank(i, iv, rv, ir);
      c.commit = 1; c.ack = 1; c.rdata = 32'hFEED_1000 | 32'(i);
      exp_q.push_back(c);
      ir = ir + 1;
    end
  endtask

  task automatic drive(ins_t p);
    pc = p.pc; alu_result = p.addr; write_data = p.wdata; byte_en = p.be;
    is_load = (p.kind == 1) || (p.kind == 3);
    is_store = (p.kind >= 2);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " instr"}, instr, 32'h0);
    chk({tag, " read_data"}, read_data, 32'h0);
    chk({tag, " instret"}, instret, 32'h0);
    chk({tag, " halted"}, 32'(halted), 32'h0);
    chk({tag, " commit"}, 32'(commit), 32'h0);
    chk({tag, " mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " mem_be"}, 32'(mem_be), 32'h0);
  endtask

  // Returns just after the rising edge with rst released: cycle 1 (IDLE) begins.
  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    commits.delete();
  endtask

  task automatic pins();
    case (phase)
      1: begin
        if (cyc == 8)  chk("pin instret after 3 alu", instret, 32'd3);
        if (cyc == 13) chk("pin load data in WB", read_data, 32'hDEAD_BEEF);
        if (cyc == 17) begin
          chk("pin store we", 32'(mem_we), 32'd1);
          chk("pin store addr", mem_addr, 32'h100);
          chk("pin store wdata", mem_wdata, 32'hA5A5_A5A5);
          chk("pin store be", 32'(mem_be), 32'h3);
        end
        if (cyc == 18) chk("pin store keeps read_data", read_data, 32'hDEAD_BEEF);
        if (cyc == 26) chk("pin ack on last wd cycle", 32'(halted), 32'd0);
      end
      2: begin
        if (cyc == 3) chk("pin instret preload", instret, 32'hFFFF_FFFF);
        if (cyc == 4) chk("pin instret wrap", instret, 32'h0);
      end
      4: begin
        if (cyc == 2) chk("pin restart fetch addr", mem_addr, 32'h200);
        if (cyc == 7) chk("pin 4th unacked req", 32'(mem_req), 32'd1);
        if (cyc == 8) begin
          chk("pin halted set", 32'(halted), 32'd1);
          chk("pin req dropped in halt", 32'(mem_req), 32'd0);
        end
      end
      default: ;
    endcase
  endtask

  task automatic run(int limit);
    cyc_t r;
    int   n;
    n = 0;
    while ((exp_q.size() > 0) && (n < limit)) begin
      r = exp_q.pop_front();
      n++;
      cyc++;
      drive(prog[r.idx]);
      @(negedge clk);
      chk($sformatf("p%0d c%0d mem_req", phase, cyc), 32'(mem_req), 32'(r.req));
      chk($sformatf("p%0d c%0d mem_we", phase, cyc), 32'(mem_we), 32'(r.we));
      chk($sformatf("p%0d c%0d mem_addr", phase, cyc), mem_addr, r.addr);
      chk($sformatf("p%0d c%0d mem_be", phase, cyc), 32'(mem_be), 32'(r.be));
      if (!r.fetch) chk($sformatf("p%0d c%0d mem_wdata", phase, cyc), mem_wdata, r.wdata);
      chk($sformatf("p%0d c%0d commit", phase, cyc), 32'(commit), 32'(r.commit));
      chk($sformatf("p%0d c%0d halted", phase, cyc), 32'(halted), 32'(r.halted));
      chk($sformatf("p%0d c%0d instr", phase, cyc), instr, r.instr);
      chk($sformatf("p%0d c%0d read_data", phase, cyc), read_data, r.rd);
      chk($sformatf("p%0d c%0d instret", phase, cyc), instret, r.instret);
      if (commit) commits.push_back(cyc);
      pins();
      mem_ack = r.ack;
      mem_rdata = r.rdata;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int p1c[8] = '{3, 5, 7, 13, 18, 22, 27, 29};

    // Phase 1: ALU stream, waited load, stores, ack on the last watchdog cycle.
    phase = 1;
    prog.delete();
    prog.push_back(mk(0, 32'h00, 32'h1111, 32'h2222, 4'h1, 32'h0000_0013, 0, 0, 0, 0));
    prog.push_back(mk(0, 32'h04, 32'h3333, 32'h4444, 4'h2, 32'h0010_0093, 0, 0, 0, 0));
    prog.push_back(mk(0, 32'h08, 32'h5555, 32'h6666, 4'h4, 32'h0020_0113, 0, 0, 0, 0));
    prog.push_back(mk(1, 32'h0C, 32'h40, 32'h7777, 4'h5, 32'h0400_2183, 32'hDEAD_BEEF, 0, 2, 0));
    prog.push_back(mk(2, 32'h10, 32'h100, 32'hA5A5_A5A5, 4'h3, 32'h1030_2023, 0, 1, 0, 0));
    prog.push_back(mk(3, 32'h14, 32'h104, 32'h1234_0000, 4'hC, 32'h1040_1023, 32'h5555_AAAA, 0, 0, 0));
    prog.push_back(mk(0, 32'h18, 32'h0, 32'h0, 4'h0, 32'h0030_0193, 0, TO - 1, 0, 0));
    prog.push_back(mk(0, 32'h1C, 32'h0, 32'h0, 4'h0, 32'h0040_0213, 0, 0, 0, 0));
    do_reset();
    expand(32'h0);
    run(1000);
    chk("p1 commit count", 32'(commits.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < commits.size()) chk($sformatf("p1 commit cycle %0d", i), 32'(commits[i]), 32'(p1c[i]));
    end

    // Phase 2: instret preloaded to all-ones wraps on the next commit.
    phase = 2;
    prog.delete();
    prog.push_back(mk(0, 32'h80, 32'h0, 32'h0, 4'h0, 32'h0000_0013, 0, 0, 0, 0));
    prog.push_back(mk(0, 32'h84, 32'h0, 32'h0, 4'h0, 32'h0000_0033, 0, 0, 0, 0));
    do_reset();
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    expand(32'hFFFF_FFFF);
    run(1000);

    // Phase 3: reset asserted while a load waits in MEM.
    phase = 3;
    prog.delete();
    prog.push_back(mk(1, 32'h300, 32'h44, 32'h0, 4'hF, 32'h0442_2083, 32'h1234_5678, 0, 0, 0));
    prog.push_back(mk(1, 32'h304, 32'h48, 32'h0, 4'hF, 32'h0482_2103, 32'hCAFE_F00D, 0, 3, 0));
    do_reset();
    expand(32'h0);
    run(9);
    chk("p3 mem_req before abort", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk_zero("mid-mem reset");

    // Phase 4: restart from pc after reset, then a fetch that never acks.
    phase = 4;
    prog.delete();
    prog.push_back(mk(0, 32'h200, 32'h9, 32'h9, 4'h9, 32'h0050_0293, 0, 0, 0, 0));
    prog.push_back(mk(0, 32'h204, 32'h0, 32'h0, 4'h0, 32'h0060_0313, 0, 0, 0, 1));
    do_reset();
    expand(32'h0);
    run(1000);
    chk("p4 commit count", 32'(commits.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
